// File: rtl/kp_pkg.sv
// Shared types and width helpers for the polyphonic Karplus-Strong engine.
package kp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } voice_state_e;

  function automatic int addr_w(input int voices, input int max_delay);
    return $clog2(voices * max_delay);
  endfunction

  function automatic int mix_w(input int data_w, input int voices);
    return data_w + $clog2(voices);
  endfunction

  // Two samples is the shortest loop the averaging filter can run on.
  function automatic int clamp_len(input int len, input int max_delay);
    if (len < 2) return 2;
    if (len > max_delay - 1) return max_delay - 1;
    return len;
  endfunction

endpackage

// File: rtl/kp_delay_ram.sv
// Shared delay-line storage: simple dual-port RAM with one-cycle registered read.
module kp_delay_ram #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic                     audio_clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge audio_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/kp_poly_engine.sv
// Time-multiplexed Karplus-Strong voices: one voice read per clock, one computed the next,
// all sharing a single delay RAM, filter and mix accumulator.
module kp_poly_engine
  import kp_pkg::*;
#(
  parameter int VOICES      = 4,
  parameter int DATA_W      = 24,
  parameter int NOISE_W     = 16,
  parameter int MAX_DELAY   = 1024,
  parameter int DECAY_W     = 12,
  parameter int SILENCE_THR = 0
) (
  input  logic                                      audio_clk,
  input  logic                                      reset,
  input  logic                                      sample_tick,
  input  logic signed [NOISE_W-1:0]                 noise,
  input  logic [VOICES-1:0]                         trig,
  input  logic [7*VOICES-1:0]                       velocity,
  input  logic [$clog2(MAX_DELAY)*VOICES-1:0]       delay_len,
  input  logic [DECAY_W*VOICES-1:0]                 decay,
  output logic signed [DATA_W+$clog2(VOICES)-1:0]   mix_out,
  output logic                                      mix_valid,
  output logic [VOICES-1:0]                         voice_active,
  output logic                                      busy,
  output logic                                      overrun
);

  localparam int LEN_W  = $clog2(MAX_DELAY);
  localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int ADDR_W = addr_w(VOICES, MAX_DELAY);
  localparam int MIX_W  = mix_w(DATA_W, VOICES);
  localparam int PROD_W = NOISE_W + 8;
  localparam int GAIN_W = DATA_W + DECAY_W + 1;

  function automatic logic signed [DATA_W-1:0] scale_noise(input logic signed [NOISE_W-1:0] n,
                                                           input logic [6:0] vel);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(n) * PROD_W'($signed({1'b0, vel}));
    return DATA_W'(p);
  endfunction

  function automatic logic signed [DATA_W-1:0] filt_avg(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    return s[DATA_W:1];
  endfunction

  function automatic logic signed [DATA_W-1:0] filt_gain(input logic signed [DATA_W-1:0] avg,
                                                         input logic [DECAY_W-1:0] g);
    logic signed [GAIN_W-1:0] p;
    p = GAIN_W'(avg) * GAIN_W'($signed({1'b0, g}));
    return p[DECAY_W +: DATA_W];
  endfunction

  function automatic logic is_silent(input logic signed [DATA_W-1:0] y);
    logic signed [DATA_W:0] ye, thr;
    ye  = (DATA_W+1)'(y);
    thr = (DATA_W+1)'(SILENCE_THR);
    return (ye <= thr) && (ye >= -thr);
  endfunction

  function automatic logic [ADDR_W-1:0] voice_addr(input logic [VIDX_W-1:0] v,
                                                   input logic [LEN_W-1:0] p);
    return ADDR_W'(int'(v) * MAX_DELAY + int'(p));
  endfunction

  voice_state_e             state   [VOICES];
  logic [LEN_W-1:0]         ptr     [VOICES];
  logic [LEN_W-1:0]         len_r   [VOICES];
  logic [LEN_W-1:0]         sil_cnt [VOICES];
  logic [DECAY_W-1:0]       dec_r   [VOICES];
  logic signed [DATA_W-1:0] prev    [VOICES];
  logic [VOICES-1:0]        pending;

  logic                     rd_vld_p0;
  logic [VIDX_W-1:0]        rd_voice_p0;
  logic                     vld_p1;
  logic [VIDX_W-1:0]        voice_p1;
  logic signed [MIX_W-1:0]  acc_p1;
  logic signed [DATA_W-1:0] ram_q_p1;

  voice_state_e             nx_state;
  logic [LEN_W-1:0]         nx_ptr, nx_sil;
  logic signed [DATA_W-1:0] nx_prev, contrib, start_p1, y_p1;
  logic                     wr_en;
  logic [VOICES-1:0]        consume;

  kp_delay_ram #(
    .DEPTH  (VOICES * MAX_DELAY),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .audio_clk (audio_clk),
    .we        (vld_p1 & wr_en),
    .waddr     (voice_addr(voice_p1, ptr[voice_p1])),
    .wdata     (contrib),
    .raddr     (voice_addr(rd_voice_p0, ptr[rd_voice_p0])),
    .rdata     (ram_q_p1)
  );

  // p1: voice_p1's delay-line sample is on ram_q_p1; run its FSM and filter
  always_comb begin
    nx_state = state[voice_p1];
    nx_ptr   = ptr[voice_p1];
    nx_prev  = prev[voice_p1];
    nx_sil   = sil_cnt[voice_p1];
    wr_en    = 1'b0;
    contrib  = '0;
    consume  = '0;
    y_p1     = '0;
    start_p1 = scale_noise(noise, velocity[int'(voice_p1)*7 +: 7]);
    if (vld_p1) consume[voice_p1] = pending[voice_p1];
    if (pending[voice_p1]) begin
      nx_state = ST_LOAD;
      nx_ptr   = '0;
      nx_prev  = '0;
      nx_sil   = '0;
    end else begin
      case (state[voice_p1])
        ST_LOAD: begin
          wr_en   = 1'b1;
          contrib = start_p1;
          nx_prev = start_p1;
          if (ptr[voice_p1] == len_r[voice_p1] - LEN_W'(1)) begin
            nx_ptr   = '0;
            nx_state = ST_PLAY;
          end else begin
            nx_ptr = ptr[voice_p1] + LEN_W'(1);
          end
        end
        ST_PLAY: begin
          y_p1    = filt_gain(filt_avg(ram_q_p1, prev[voice_p1]), dec_r[voice_p1]);
          wr_en   = 1'b1;
          contrib = y_p1;
          nx_prev = ram_q_p1;
          nx_ptr  = (ptr[voice_p1] == len_r[voice_p1] - LEN_W'(1)) ? '0
                                                                   : ptr[voice_p1] + LEN_W'(1);
          if (is_silent(y_p1)) begin
            nx_sil = sil_cnt[voice_p1] + LEN_W'(1);
            if (nx_sil == len_r[voice_p1]) nx_state = ST_IDLE;
          end else begin
            nx_sil = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge audio_clk) begin
    if (vld_p1 && pending[voice_p1]) begin
      len_r[voice_p1] <= LEN_W'(clamp_len(int'(delay_len[int'(voice_p1)*LEN_W +: LEN_W]), MAX_DELAY));
      dec_r[voice_p1] <= decay[int'(voice_p1)*DECAY_W +: DECAY_W];
    end
  end

  always_ff @(posedge audio_clk) begin
    if (reset) begin
      pending      <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      rd_vld_p0    <= 1'b0;
      rd_voice_p0  <= '0;
      vld_p1       <= 1'b0;
      voice_p1     <= '0;
      acc_p1       <= '0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      voice_active <= '0;
      for (int v = 0; v < VOICES; v++) begin
        state[v]   <= ST_IDLE;
        ptr[v]     <= '0;
        prev[v]    <= '0;
        sil_cnt[v] <= '0;
      end
    end else begin
      mix_valid <= 1'b0;
      pending   <= (pending & ~consume) | trig;
      // p0: address for rd_voice_p0 is on the RAM read port this cycle
      vld_p1    <= rd_vld_p0;
      voice_p1  <= rd_voice_p0;
      if (rd_vld_p0) begin
        rd_voice_p0 <= rd_voice_p0 + VIDX_W'(1);
        if (rd_voice_p0 == VIDX_W'(VOICES - 1)) rd_vld_p0 <= 1'b0;
      end
      if (vld_p1) begin
        state[voice_p1]        <= nx_state;
        ptr[voice_p1]          <= nx_ptr;
        prev[voice_p1]         <= nx_prev;
        sil_cnt[voice_p1]      <= nx_sil;
        voice_active[voice_p1] <= (nx_state != ST_IDLE);
        acc_p1                 <= acc_p1 + MIX_W'(contrib);
        if (voice_p1 == VIDX_W'(VOICES - 1)) begin
          mix_out   <= acc_p1 + MIX_W'(contrib);
          mix_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end
      if (sample_tick) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          busy        <= 1'b1;
          rd_vld_p0   <= 1'b1;
          rd_voice_p0 <= '0;
          acc_p1      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_kp_poly_engine.sv
// Scoreboard bench: a per-voice string model predicts each sweep's mix; a monitor checks mix_valid.
module tb_kp_poly_engine;

  localparam int VOICES      = 4;
  localparam int DATA_W      = 24;
  localparam int NOISE_W     = 16;
  localparam int MAX_DELAY   = 1024;
  localparam int DECAY_W     = 12;
  localparam int SILENCE_THR = 0;
  localparam int LEN_W       = $clog2(MAX_DELAY);
  localparam int MIX_W       = DATA_W + $clog2(VOICES);

  logic                        audio_clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        sample_tick = 1'b0;
  logic signed [NOISE_W-1:0]   noise = '0;
  logic [VOICES-1:0]           trig = '0;
  logic [7*VOICES-1:0]         velocity = '0;
  logic [LEN_W*VOICES-1:0]     delay_len = '0;
  logic [DECAY_W*VOICES-1:0]   decay = '0;
  logic signed [MIX_W-1:0]     mix_out;
  logic                        mix_valid;
  logic [VOICES-1:0]           voice_active;
  logic                        busy;
  logic                        overrun;

  kp_poly_engine #(
    .VOICES(VOICES), .DATA_W(DATA_W), .NOISE_W(NOISE_W), .MAX_DELAY(MAX_DELAY),
    .DECAY_W(DECAY_W), .SILENCE_THR(SILENCE_THR)
  ) dut (
    .audio_clk(audio_clk), .reset(reset), .sample_tick(sample_tick), .noise(noise),
    .trig(trig), .velocity(velocity), .delay_len(delay_len), .decay(decay),
    .mix_out(mix_out), .mix_valid(mix_valid), .voice_active(voice_active),
    .busy(busy), .overrun(overrun)
  );

  always #5 audio_clk = ~audio_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  typedef struct {
    longint            mix;
    logic [VOICES-1:0] act;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: each voice is a ring of samples stepped once per sweep.
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2;
  int     m_st [VOICES];
  int     m_len[VOICES];
  int     m_dec[VOICES];
  int     m_ptr[VOICES];
  int     m_sil[VOICES];
  longint m_prev[VOICES];
  bit     m_pend[VOICES];
  longint m_line[VOICES][MAX_DELAY];

  int     drv_vel[VOICES];
  int     drv_len[VOICES];
  int     drv_dec[VOICES];
  longint drv_noise;

  function automatic longint wrap_d(input longint x);
    longint m;
    m = longint'(1) <<< DATA_W;
    x = x & (m - 1);
    if (x >= m / 2) x = x - m;
    return x;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int ref_clamp(input int l);
    if (l < 2) return 2;
    if (l > MAX_DELAY - 1) return MAX_DELAY - 1;
    return l;
  endfunction

  function automatic longint labs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_st[v] = M_IDLE; m_ptr[v] = 0; m_prev[v] = 0; m_sil[v] = 0; m_pend[v] = 0;
    end
  endtask

  task automatic model_sweep(input logic [VOICES-1:0] mid_mask, input int mid_cyc,
                             output longint mix, output logic [VOICES-1:0] act);
    longint c, q, avg, y;
    mix = 0;
    for (int v = 0; v < VOICES; v++) begin
      c = 0;
      // a trigger landing before this voice's slot is seen by it in this sweep
      if (m_pend[v] || (mid_mask[v] && mid_cyc <= 1 + v)) begin
        m_pend[v] = 0;
        m_st[v] = M_LOAD; m_len[v] = ref_clamp(drv_len[v]); m_dec[v] = drv_dec[v];
        m_ptr[v] = 0; m_prev[v] = 0; m_sil[v] = 0;
      end else if (m_st[v] == M_LOAD) begin
        c = wrap_d(drv_noise * drv_vel[v]);
        m_line[v][m_ptr[v]] = c;
        m_prev[v] = c;
        m_ptr[v]++;
        if (m_ptr[v] == m_len[v]) begin
          m_ptr[v] = 0; m_st[v] = M_PLAY;
        end
      end else if (m_st[v] == M_PLAY) begin
        q = m_line[v][m_ptr[v]];
        avg = floor_div(q + m_prev[v], 2);
        y = wrap_d(floor_div(avg * m_dec[v], longint'(1) <<< DECAY_W));
        m_line[v][m_ptr[v]] = y;
        c = y;
        m_prev[v] = q;
        m_ptr[v] = (m_ptr[v] + 1) % m_len[v];
        if (labs(y) <= SILENCE_THR) begin
          m_sil[v]++;
          if (m_sil[v] >= m_len[v]) m_st[v] = M_IDLE;
        end else begin
          m_sil[v] = 0;
        end
      end
      if (mid_mask[v] && mid_cyc >= 2 + v) m_pend[v] = 1;
      mix += c;
      act[v] = (m_st[v] != M_IDLE);
    end
  endtask

  task automatic apply_drv();
    for (int v = 0; v < VOICES; v++) begin
      velocity[v*7 +: 7]             = 7'(drv_vel[v]);
      delay_len[v*LEN_W +: LEN_W]    = LEN_W'(drv_len[v]);
      decay[v*DECAY_W +: DECAY_W]    = DECAY_W'(drv_dec[v]);
    end
    noise = NOISE_W'(drv_noise);
  endtask

  // Called on a falling edge with the engine idle; returns on the falling edge where mix_valid is high.
  task automatic do_sweep(input logic [VOICES-1:0] mid_mask, input int mid_cyc, input int xtick);
    exp_t e;
    apply_drv();
    model_sweep(mid_mask, mid_cyc, e.mix, e.act);
    exp_q.push_back(e);
    for (int c = 0; c <= VOICES + 1; c++) begin
      sample_tick = (c == 0) || (c == xtick);
      trig = (c == mid_cyc) ? mid_mask : '0;
      @(posedge audio_clk);
      @(negedge audio_clk);
      chk("busy_timing", busy, longint'(c <= VOICES));
      chk("mix_valid_timing", mix_valid, longint'(c == VOICES + 1));
    end
    sample_tick = 1'b0;
    trig = '0;
  endtask

  task automatic sweep();
    do_sweep('0, -1, -1);
  endtask

  task automatic idle_trig(input logic [VOICES-1:0] mask);
    trig = mask;
    for (int v = 0; v < VOICES; v++) if (mask[v]) m_pend[v] = 1;
    @(posedge audio_clk);
    @(negedge audio_clk);
    trig = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_tick = 1'b0;
    trig = '0;
    repeat (2) @(posedge audio_clk);
    @(negedge audio_clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_all(input int vel, input int len, input int dec, input longint nz);
    for (int v = 0; v < VOICES; v++) begin
      drv_vel[v] = vel; drv_len[v] = len; drv_dec[v] = dec;
    end
    drv_noise = nz;
  endtask

  always @(negedge audio_clk) begin
    if (mix_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_mix_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mix_out", mix_out, mon_e.mix);
        chk("voice_active", voice_active, mon_e.act);
      end
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: bench did not complete within the cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [NOISE_W-1:0] nz;
    logic [VOICES-1:0]         mm;
    set_all(0, 4, 0, 0);
    model_reset();
    @(negedge audio_clk);
    do_reset();

    chk("rst_mix_out", mix_out, 0);
    chk("rst_mix_valid", mix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_voice_active", voice_active, 0);

    // idle sweep: latency and busy window checked inside do_sweep
    sweep();
    chk("idle_mix", mix_out, 0);
    chk("idle_active", voice_active, 0);

    // single pluck, full and half decay
    set_all(0, 4, 0, 0);
    drv_vel[0] = 1; drv_dec[0] = 4095; drv_noise = 100;
    idle_trig(4'b0001);
    sweep();
    for (int s = 1; s <= 4; s++) begin
      sweep();
      chk("pluck_load", mix_out, 100);
    end
    sweep();
    chk("pluck_decay4095", mix_out, 99);
    drv_dec[0] = 2048;
    idle_trig(4'b0001);
    sweep();
    repeat (4) sweep();
    sweep();
    chk("pluck_decay2048", mix_out, 50);

    // shortest loop: delay_len=1 clamps to 2
    do_reset();
    set_all(0, 4, 0, 100);
    drv_vel[0] = 1; drv_len[0] = 1; drv_dec[0] = 4095;
    idle_trig(4'b0001);
    sweep();
    sweep(); sweep();
    chk("clamp_second_load", mix_out, 100);
    sweep();
    chk("clamp_first_play", mix_out, 99);
    repeat (3) sweep();

    // silence release
    do_reset();
    set_all(0, 4, 0, 2);
    drv_vel[0] = 1; drv_len[0] = 2; drv_dec[0] = 0;
    idle_trig(4'b0001);
    sweep();
    sweep(); chk("sil_s1", mix_out, 2);
    sweep(); chk("sil_s2", mix_out, 2);
    sweep(); chk("sil_s3", mix_out, 0);
    chk("sil_active_s3", voice_active[0], 1);
    sweep(); chk("sil_s4", mix_out, 0);
    chk("sil_active_s4", voice_active[0], 0);
    sweep(); chk("sil_s5", mix_out, 0);

    // retrigger in PLAY together with all other voices
    do_reset();
    set_all(127, 4, 4095, 100);
    idle_trig(4'b0001);
    sweep();
    repeat (6) sweep();
    idle_trig(4'b1111);
    sweep();
    sweep();
    chk("retrig_all_mix", mix_out, 50800);
    // trigger coinciding with voice 1's own slot stays pending for the next sweep
    do_sweep(4'b0010, 3, -1);
    sweep();
    sweep();

    // overrun: second tick at cycle 3 is ignored and sticky
    do_sweep('0, -1, 3);
    chk("overrun_set", overrun, 1);
    repeat (3) @(negedge audio_clk);
    chk("overrun_no_extra_valid", mix_valid, 0);
    sweep();
    chk("overrun_sticky", overrun, 1);

    // reset in mid-sweep aborts it
    apply_drv();
    sample_tick = 1'b1;
    @(posedge audio_clk); @(negedge audio_clk);
    sample_tick = 1'b0;
    @(posedge audio_clk); @(negedge audio_clk);
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge audio_clk); @(negedge audio_clk);
    reset = 1'b0;
    model_reset();
    chk("abort_busy", busy, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_active", voice_active, 0);
    chk("abort_mix_out", mix_out, 0);
    for (int i = 0; i < VOICES + 3; i++) begin
      @(negedge audio_clk);
      chk("abort_no_valid", mix_valid, 0);
    end

    // randomized run: voice 0 at the longest loop, others retriggered at random
    set_all(64, 4, 3000, 0);
    drv_vel[0] = 100; drv_len[0] = MAX_DELAY - 1; drv_dec[0] = 4000;
    idle_trig(4'b0001);
    sweep();
    for (int s = 0; s < 2 * (MAX_DELAY - 1) + 12; s++) begin
      nz = NOISE_W'($urandom);
      drv_noise = nz;
      for (int v = 0; v < VOICES; v++) begin
        drv_vel[v] = $urandom_range(0, 127);
        drv_len[v] = (v == 0) ? $urandom_range(0, MAX_DELAY - 1) : $urandom_range(0, 15);
        drv_dec[v] = $urandom_range(0, (1 << DECAY_W) - 1);
      end
      mm = '0;
      if ($urandom_range(0, 7) == 0) mm = VOICES'($urandom_range(1, (1 << VOICES) - 1)) & ~VOICES'(1);
      do_sweep(mm, $urandom_range(0, VOICES + 1), -1);
    end

    repeat (4) @(negedge audio_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kp_poly_engine.md
Name: kp_poly_engine

Overview:
- Time-multiplexed polyphonic Karplus-Strong voice engine and the successor to the single-voice KP core.
- Serves VOICES independent plucked-string voices from one shared delay RAM, with one filter/gain datapath and one voice processed per clock.
- Per-voice pitch, decay and velocity; automatic silence release per voice.
- Sits between the LFSR noise source / trigger debouncers and the DAC output stage, and produces one mixed sample per sample_tick.

Parameters:
VOICES, 4, number of voices (≥1)
DATA_W, 24, delay-line sample width (signed)
NOISE_W, 16, noise input width (signed); NOISE_W+8 ≤ DATA_W
MAX_DELAY, 1024, per-voice delay capacity (power of 2)
DECAY_W, 12, unsigned decay gain width (gain = decay/2^DECAY_W)
SILENCE_THR, 0, |sample| at or below this counts as silent

Ports:
audio_clk  in  1  sole clock
reset  in  1  synchronous, active-high
sample_tick  in  1  one-cycle pulse per audio sample; starts a sweep
noise  in  NOISE_W  signed excitation from LFSR, advances every clock
trig  in  VOICES  per-voice single-cycle trigger from debouncer
velocity  in  7*VOICES  unsigned per-voice velocity
delay_len  in  clog2(MAX_DELAY)*VOICES  per-voice period in samples
decay  in  DECAY_W*VOICES  per-voice feedback gain
mix_out  out  DATA_W+clog2(VOICES)  signed sum of voice outputs
mix_valid  out  1  one-cycle pulse when mix_out updates
voice_active  out  VOICES  voice is in LOAD or PLAY
busy  out  1  sweep in progress
overrun  out  1  sticky; set on sample_tick while busy

Behaviour:
- Reset values:
  - all voices IDLE; ptr, prev, silence counters 0; pending triggers cleared
  - mix_out 0, mix_valid 0, busy 0, overrun 0, voice_active 0
  - RAM contents not cleared
  - reset mid-sweep aborts the sweep with no mix_valid
- Triggers: trig[v] sets pending[v]. pending[v] is consumed at voice v's slot in the next sweep. A trig coinciding with consumption keeps pending set.
- Sweep timing, relative to a tick at cycle 0:
  - busy=1 from cycle 1
  - read for voice v issued at cycle 1+v; RAM read latency 1
  - compute and write for voice v at cycle 2+v, same address
  - mix_out registered and mix_valid pulsed at cycle VOICES+2; busy drops the same cycle
  - tick-to-mix_valid latency is VOICES+2
  - sample_tick while busy is ignored and sets overrun
- RAM address: {v, ptr[v]}; size VOICES*MAX_DELAY words.
- Voice FSM, evaluated at the voice's slot:
  - IDLE:
    - contributes 0, no write
    - if pending: latch len=clamp(delay_len,2,MAX_DELAY-1) and decay; ptr=0; prev=0; go to LOAD
  - LOAD:
    - write start=sign-extend(noise*velocity) to DATA_W; contribution=start; prev=start
    - at ptr==len-1: ptr=0, go to PLAY; else ptr+1
    - pending retrigger restarts LOAD with ptr=0
  - PLAY:
    - avg=(q+prev)>>>1, computed at DATA_W+1 bits, floor
    - y=(avg*decay)>>>DECAY_W, truncated to DATA_W
    - write y; contribution=y; prev=q
    - ptr wraps len-1 → 0
    - silence counter: incremented when |y|≤SILENCE_THR, else cleared
    - when the counter reaches len: go to IDLE
    - pending retrigger has priority over silence release: go to LOAD
- Live delay_len/decay changes are ignored until the next trigger.
- voice_active[v] updates at the voice's compute cycle.
- Mix:
  - accumulator cleared at cycle 1
  - sums contributions at full width DATA_W+clog2(VOICES); no saturation

Decomposition:
- Shared package kp_pkg:
  - voice state enum (IDLE/LOAD/PLAY)
  - clamp_len function
  - width-derivation constants (ADDR_W, MIX_W)
- One sub-module kp_delay_ram: inferred simple dual-port RAM, 1-cycle registered read, write enable, VOICES*MAX_DELAY x DATA_W.
- FSM, filter and mixer stay in kp_poly_engine.

Test Plan:
- Idle after reset, VOICES=4: tick → mix_valid exactly 6 cycles later, mix_out=0, voice_active=0, busy high cycles 1-5.
- Voice 0 pluck, noise held at 100, velocity 1, len=4, decay=4095:
  - sweeps 1-4 give mix_out=100
  - sweep 5 gives 99
  - with decay=2048, sweep 5 gives 50
- Clamp: delay_len=1 → voice loads 2 samples then PLAYs with period 2; delay_len=MAX_DELAY-1 wraps correctly at ptr=MAX_DELAY-2.
- Silence release: noise=2, velocity 1, len=2, decay=0:
  - mix 2,2,0,0
  - voice_active[0] falls at sweep 4
  - next tick contributes 0
- Retrigger in PLAY plus simultaneous trig on all 4 voices with noise=100, velocity=127: next sweep all re-LOAD; mix_out=50800.
- Overrun: second tick at cycle 3 of a sweep → overrun=1 sticky, only one mix_valid; reset clears overrun and aborts the sweep.
